// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
// The optional write trace is enabled with `DMEM_WRITE_TRACE_EN in dmem_wait_responder.
package dmem_pkg;

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;

    // Full-width range compare so that out-of-range addresses never alias onto a valid word.
    function automatic logic [1:0] addr_check(input logic [31:0] addr, input logic [31:0] limit);
        logic [1:0] code;
        code = 2'b00;
        if (addr[1:0] != 2'b00) begin
            code = code | ERR_MISALIGN;
        end
        if (addr >= limit) begin
            code = code | ERR_RANGE;
        end
        return code;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the responder: DEPTH x 32 bits, synchronous write, asynchronous read.
module dmem_array #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [31:0]       d_i,
    output logic [31:0]       q_o
);

    logic [31:0] mem_q [DEPTH];

    // Store port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= d_i;
        end
    end

    assign q_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_wait_responder.sv
// Load/store responder completing each request after LATENCY wait cycles with a one-cycle ready pulse.
// Define DMEM_WRITE_TRACE_EN to add last_wr_addr / last_wr_data / wr_count trace outputs.
module dmem_wait_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
`ifdef DMEM_WRITE_TRACE_EN
    ,
    output logic [31:0] last_wr_addr,
    output logic [31:0] last_wr_data,
    output logic [15:0] wr_count
`endif
);

    localparam int                ADDR_W   = $clog2(DEPTH);
    localparam logic [31:0]       LIMIT    = 32'(4 * DEPTH);
    localparam logic [LAT_W-1:0]  CNT_INIT = LAT_W'(LATENCY - 1);

    state_e            state_q;
    logic [LAT_W-1:0]  cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic [1:0]        errc_q;
    logic [31:0]       rdata_q;
    logic              ready_q;
    logic              err_q;
    logic              busy_q;

    logic [1:0]        errc_d;
    logic [31:0]       rdata_d;
    logic [31:0]       arr_rd_s;
    logic              accept_s;
    logic              commit_s;

    assign errc_d   = addr_check(addr, LIMIT);
    assign accept_s = (state_q == IDLE) && req;
    assign commit_s = (state_q == WAIT) && (cnt_q == '0) && we_q && (errc_q == 2'b00);

    dmem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .we_i  (commit_s),
        .idx_i (idx_q),
        .d_i   (wdata_q),
        .q_o   (arr_rd_s)
    );

    // Erroneous loads return zero instead of whatever the truncated index points at.
    always_comb begin
        if (errc_q != 2'b00) begin
            rdata_d = 32'd0;
        end else begin
            rdata_d = arr_rd_s;
        end
    end

    // Request FSM with wait counter and registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'd0;
            errc_q  <= 2'b00;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (req) begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_INIT;
                        we_q    <= we;
                        idx_q   <= addr[ADDR_W+1:2];
                        wdata_q <= wdata;
                        errc_q  <= errc_d;
                        busy_q  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - LAT_W'(1);
                    end else begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        err_q   <= (errc_q != 2'b00);
                        if (!we_q) begin
                            rdata_q <= rdata_d;
                        end
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = busy_q;

`ifdef DMEM_WRITE_TRACE_EN
    logic [31:0] addr_q;
    logic [31:0] last_wr_addr_q;
    logic [31:0] last_wr_data_q;
    logic [15:0] wr_count_q;

    // Trace log: keeps the full request address and records each committed store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q         <= 32'd0;
            last_wr_addr_q <= 32'd0;
            last_wr_data_q <= 32'd0;
            wr_count_q     <= 16'd0;
        end else begin
            if (accept_s) begin
                addr_q <= addr;
            end
            if (commit_s) begin
                last_wr_addr_q <= addr_q;
                last_wr_data_q <= wdata_q;
                wr_count_q     <= wr_count_q + 16'd1;
            end
        end
    end

    assign last_wr_addr = last_wr_addr_q;
    assign last_wr_data = last_wr_data_q;
    assign wr_count     = wr_count_q;
`endif

endmodule

// File: tb/tb_dmem_wait_responder.sv
// Self-checking bench for dmem_wait_responder: directed table, reset-abort sequence, randomized model check.
module tb_dmem_wait_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;
`ifdef DMEM_WRITE_TRACE_EN
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;
    logic [15:0] wr_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl_mem [DEPTH];
    bit          mdl_vld [DEPTH];

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        bit          exp_e;
    } vec_t;

    vec_t tbl [14];

    dmem_wait_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .ready (ready),
        .err   (err),
        .busy  (busy)
`ifdef DMEM_WRITE_TRACE_EN
        ,
        .last_wr_addr (last_wr_addr),
        .last_wr_data (last_wr_data),
        .wr_count     (wr_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit ref_err(input logic [31:0] a);
        longint ua;
        ua = longint'(a);
        return ((ua % 4) != 0) || (ua >= longint'(4 * DEPTH));
    endfunction

    // One complete transaction; called just after a rising edge with the DUT idle.
    task automatic xact(input string name, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit exp_e, input logic [31:0] exp_rd);
        int lat;
        lat = -1;
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        for (int i = 0; i <= 20; i++) begin
            if (ready === 1'b1) begin
                lat = i;
                break;
            end
            if (busy !== 1'b1) begin
                chk({name, "_busy"}, 32'(busy), 32'd1);
            end
            @(posedge clk); #1;
        end
        chk({name, "_latency"}, 32'(lat), 32'(LAT));
        chk({name, "_err"}, 32'(err), 32'(exp_e));
        if (!w) chk({name, "_rdata"}, rdata, exp_rd);
        req = 1'b0;
        @(posedge clk); #1;
        chk({name, "_ready_fall"}, 32'(ready), 32'd0);
        chk({name, "_busy_fall"}, 32'(busy), 32'd0);
        chk({name, "_err_hold"}, 32'(err), 32'(exp_e));
        if (!w) chk({name, "_rdata_hold"}, rdata, exp_rd);
        if (w && !ref_err(a)) begin
            mdl_mem[a / 4] = d;
            mdl_vld[a / 4] = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        bit          w;
        bit          e;
        bit          saw_ready;

        tbl[0]  = '{1'b1, 32'd84,          32'd7,          32'd0,          1'b0};
        tbl[1]  = '{1'b0, 32'd84,          32'd0,          32'd7,          1'b0};
        tbl[2]  = '{1'b1, 32'd86,          32'd5,          32'd0,          1'b1};
        tbl[3]  = '{1'b0, 32'd84,          32'd0,          32'd7,          1'b0};
        tbl[4]  = '{1'b1, 32'd0,           32'h0000_1234,  32'd0,          1'b0};
        tbl[5]  = '{1'b1, 32'd256,         32'd9,          32'd0,          1'b1};
        tbl[6]  = '{1'b0, 32'd0,           32'd0,          32'h0000_1234,  1'b0};
        tbl[7]  = '{1'b1, 32'd3,           32'd1,          32'd0,          1'b1};
        tbl[8]  = '{1'b1, 32'd252,         32'hAAAA_5555,  32'd0,          1'b0};
        tbl[9]  = '{1'b0, 32'd252,         32'd0,          32'hAAAA_5555,  1'b0};
        tbl[10] = '{1'b0, 32'd260,         32'd0,          32'd0,          1'b1};
        tbl[11] = '{1'b0, 32'd2,           32'd0,          32'd0,          1'b1};
        tbl[12] = '{1'b1, 32'hFFFF_FF00,   32'hDEAD_BEEF,  32'd0,          1'b1};
        tbl[13] = '{1'b1, 32'd80,          32'h0000_0055,  32'd0,          1'b0};

        for (int i = 0; i < DEPTH; i++) mdl_vld[i] = 1'b0;

        #10;
        chk("reset_ready", 32'(ready), 32'd0);
        chk("reset_busy",  32'(busy),  32'd0);
        chk("reset_err",   32'(err),   32'd0);
        chk("reset_rdata", rdata,      32'd0);
        #12 reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            xact($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp_e, tbl[i].exp_rd);
        end
        xact("alias_chk", 1'b0, 32'd0, 32'd0, 1'b0, 32'h0000_1234);

        // Reset pulsed during WAIT must abort the store to word 20.
        req = 1'b1; we = 1'b1; addr = 32'd80; wdata = 32'd3;
        @(posedge clk); #1;
        chk("abort_busy_wait", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("abort_ready_rst", 32'(ready), 32'd0);
        chk("abort_busy_rst",  32'(busy),  32'd0);
        chk("abort_rdata_rst", rdata,      32'd0);
        req = 1'b0;
        #3 reset = 1'b1;
        saw_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) saw_ready = 1'b1;
        end
        chk("abort_no_ready", 32'(saw_ready), 32'd0);
        xact("abort_load", 1'b0, 32'd80, 32'd0, 1'b0, 32'h0000_0055);

        for (int i = 0; i < DEPTH; i++) begin
            xact("preload", 1'b1, 32'(4 * i), $urandom(), 1'b0, 32'd0);
        end

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: a = 32'(4 * $urandom_range(0, DEPTH - 1));
                6:       a = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
                7:       a = 32'(4 * DEPTH + 4 * $urandom_range(0, DEPTH - 1));
                8:       a = $urandom() | 32'h8000_0000;
                default: a = ($urandom_range(0, 1) == 1) ? 32'(4 * DEPTH) : 32'(4 * DEPTH - 4);
            endcase
            w = 1'($urandom_range(0, 1));
            d = $urandom();
            e = ref_err(a);
            exp_rd = e ? 32'd0 : mdl_mem[a / 4];
            xact($sformatf("rnd%0d", n), w, a, d, e, exp_rd);
        end

`ifdef DMEM_WRITE_TRACE_EN
        reset = 1'b0;
        #2;
        chk("trace_rst_count", 32'(wr_count), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        xact("trace_st1", 1'b1, 32'd16, 32'h1111_0001, 1'b0, 32'd0);
        xact("trace_st2", 1'b1, 32'd40, 32'h2222_0002, 1'b0, 32'd0);
        xact("trace_bad", 1'b1, 32'd41, 32'h3333_0003, 1'b1, 32'd0);
        chk("trace_count", 32'(wr_count), 32'd2);
        chk("trace_addr",  last_wr_addr,  32'd40);
        chk("trace_data",  last_wr_data,  32'h2222_0002);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
